// File: rtl/apb_gpio_seq.sv
// APB-programmed GPIO pattern sequencer: a command FIFO of {data, hold} entries played onto seq_out.
// Optional macro GPIO_SEQ_LOOP_EN enables LOOP mode, which replays the stored entries until STOP.
module apb_gpio_seq #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               seq_out,
  output logic                      seq_active,
  output logic                      seq_done
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t        state;
  logic [47:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rd_idx;
  logic [AW:0]   level;
  logic [7:0]    level8;
  logic [15:0]   hold_val, cnt;
  logic [47:0]   head;
  logic [2:0]    addr;
  logic          wr, rd, ctrl_wr, start, stop, push, pop, push_ok, ovf_set;
  logic          empty, full, busy, overflow, loop;
  logic          unused_paddr;

  assign addr         = PADDR[4:2];
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};
  assign wr           = PSEL & PENABLE & PWRITE;
  assign rd           = PSEL & PENABLE & ~PWRITE;
  assign ctrl_wr      = wr && (addr == 3'd0);
  assign start        = ctrl_wr & PWDATA[0];
  assign stop         = ctrl_wr & PWDATA[1];
  assign push         = wr && (addr == 3'd3);

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(FIFO_DEPTH));
  assign busy   = (state != IDLE);
  assign level8 = 8'(level);

  // In LOOP mode the head is only read; otherwise LOAD consumes it.
  assign pop     = (state == LOAD) && !stop && !loop;
  assign push_ok = push && !stop && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign head    = mem[rd_idx];

  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign seq_active = busy;

`ifdef GPIO_SEQ_LOOP_EN
  logic [AW-1:0] lidx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      loop <= 1'b0;
      lidx <= '0;
    end else begin
      if (ctrl_wr) loop <= PWDATA[2];
      if (stop || state == IDLE)
        lidx <= '0;
      else if (state == LOAD && loop)
        lidx <= ({1'b0, lidx} + (AW+1)'(1) == level) ? '0 : lidx + AW'(1);
    end
  end

  assign rd_idx = loop ? rptr + lidx : rptr;
`else
  assign loop   = 1'b0;
  assign rd_idx = rptr;
`endif

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wptr] <= {PWDATA, hold_val};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      hold_val <= '0;
    end else begin
      if (wr && addr == 3'd2) hold_val <= PWDATA[15:0];
      // A new overflow in the same cycle as a STATUS read keeps the flag set.
      if (ovf_set)
        overflow <= 1'b1;
      else if (rd && addr == 3'd1)
        overflow <= 1'b0;
      if (stop) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (pop)     rptr <= rptr + AW'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      seq_out  <= '0;
      cnt      <= '0;
      seq_done <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        IDLE: if (start && !stop && !empty) state <= LOAD;
        LOAD: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            seq_out <= head[47:16];
            cnt     <= head[15:0];
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
          end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (!empty) begin
            state <= LOAD;
          end else begin
            state    <= IDLE;
            seq_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      3'd0:    PRDATA = {29'b0, loop, 2'b0};
      3'd1:    PRDATA = {16'b0, level8, 4'b0, overflow, empty, full, busy};
      3'd2:    PRDATA = {16'b0, hold_val};
      3'd4:    PRDATA = seq_out;
      default: PRDATA = '0;
    endcase
  end
endmodule

// File: tb/tb_apb_gpio_seq.sv
// Directed testbench for apb_gpio_seq; LOOP-mode vectors run only when GPIO_SEQ_LOOP_EN is defined.
module tb_apb_gpio_seq;
  localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h004, A_HOLD = 12'h008,
                          A_DATA = 12'h00C, A_OUT  = 12'h010;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA, seq_out;
  logic        PREADY, PSLVERR, seq_active, seq_done;

  int checks = 0, failures = 0;
  logic [31:0] rdata;
  logic [31:0] t_out [8], e_out [8];
  logic [31:0] t_done[8], e_done[8], t_busy[8], e_busy[8], t_lvl[8], e_lvl[8];

  apb_gpio_seq #(.APB_ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .seq_out(seq_out), .seq_active(seq_active), .seq_done(seq_done)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Tasks start and end on a falling edge; the access takes effect on the rising edge in between.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK); PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic run_trace();
    PADDR = A_STAT;
    for (int i = 0; i < 8; i++) begin
      #1;
      t_out[i]  = seq_out;
      t_done[i] = {31'b0, seq_done};
      t_busy[i] = {31'b0, seq_active};
      t_lvl[i]  = {24'b0, PRDATA[15:8]};
      @(negedge HCLK);
    end
  endtask

  task automatic cmp_trace(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_out%0d", tag, i),  t_out[i],  e_out[i]);
      check($sformatf("%s_done%0d", tag, i), t_done[i], e_done[i]);
      check($sformatf("%s_busy%0d", tag, i), t_busy[i], e_busy[i]);
      check($sformatf("%s_lvl%0d", tag, i),  t_lvl[i],  e_lvl[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (seq_active && k < 50) begin
      @(negedge HCLK);
      k++;
    end
    check(tag, {31'b0, seq_active}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("rst_out", seq_out, 32'h0);
    check("rst_active", {31'b0, seq_active}, 32'd0);
    check("rst_done", {31'b0, seq_done}, 32'd0);
    check("pready", {31'b0, PREADY}, 32'd1);
    check("pslverr", {31'b0, PSLVERR}, 32'd0);
    @(negedge HCLK);
    apb_rd(A_STAT, rdata); check("rst_status", rdata, 32'h4);

    // START on an empty FIFO, register map corners
    apb_wr(A_CTRL, 32'h1); #1 check("start_empty", {31'b0, seq_active}, 32'd0);
    apb_wr(A_CTRL, 32'h4); apb_rd(A_CTRL, rdata);
`ifdef GPIO_SEQ_LOOP_EN
    check("ctrl_loop", rdata, 32'h4);
`else
    check("ctrl_loop", rdata, 32'h0);
`endif
    apb_wr(A_CTRL, 32'h0);
    apb_wr(12'h014, 32'hFFFF_FFFF); apb_rd(12'h014, rdata); check("unmapped", rdata, 32'h0);
    apb_wr(A_HOLD, 32'hFFFF_FFFF);  apb_rd(A_HOLD, rdata);  check("hold_mask", rdata, 32'h0000_FFFF);
    apb_rd(A_DATA, rdata); check("data_rd", rdata, 32'h0);

    // Single entry, HOLD=3
    apb_wr(A_HOLD, 32'd3); apb_wr(A_DATA, 32'hA5);
    apb_rd(A_STAT, rdata); check("one_status", rdata, 32'h100);
    apb_wr(A_CTRL, 32'h1);
    run_trace();
    e_out  = '{32'h0, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5};
    e_done = '{0, 0, 0, 0, 0, 1, 0, 0};
    e_busy = '{1, 1, 1, 1, 1, 0, 0, 0};
    e_lvl  = '{1, 0, 0, 0, 0, 0, 0, 0};
    cmp_trace("one");
    apb_rd(A_OUT, rdata); check("out_rd", rdata, 32'hA5);

    // Two entries, HOLD 0 then 1
    apb_wr(A_HOLD, 32'd0); apb_wr(A_DATA, 32'h1);
    apb_wr(A_HOLD, 32'd1); apb_wr(A_DATA, 32'h2);
    apb_rd(A_STAT, rdata); check("two_status", rdata, 32'h200);
    apb_wr(A_CTRL, 32'h1);
    run_trace();
    e_out  = '{32'hA5, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2};
    e_done = '{0, 0, 0, 0, 0, 1, 0, 0};
    e_busy = '{1, 1, 1, 1, 1, 0, 0, 0};
    e_lvl  = '{2, 1, 1, 0, 0, 0, 0, 0};
    cmp_trace("two");

    // Overflow on the fifth push, cleared by the STATUS read
    for (int i = 0; i < 5; i++) apb_wr(A_DATA, 32'h10 + i);
    apb_rd(A_STAT, rdata); check("ovf_status1", rdata, 32'h40A);
    apb_rd(A_STAT, rdata); check("ovf_status2", rdata, 32'h402);
    apb_wr(A_CTRL, 32'h2);
    apb_rd(A_STAT, rdata); check("idle_flush", rdata, 32'h4);

    // STOP during the hold of the first of three entries
    apb_wr(A_HOLD, 32'd2);
    apb_wr(A_DATA, 32'h11); apb_wr(A_DATA, 32'h22); apb_wr(A_DATA, 32'h33);
    apb_wr(A_CTRL, 32'h1);
    @(negedge HCLK);
    apb_wr(A_CTRL, 32'h2);
    #1;
    check("stop_active", {31'b0, seq_active}, 32'd0);
    check("stop_out", seq_out, 32'h11);
    check("stop_done", {31'b0, seq_done}, 32'd0);
    apb_rd(A_STAT, rdata); check("stop_status", rdata, 32'h4);

    // Push while busy, before the hold-exit decision
    apb_wr(A_HOLD, 32'd1); apb_wr(A_DATA, 32'h7);
    apb_wr(A_CTRL, 32'h1);
    apb_wr(A_DATA, 32'h8);
    #1 check("busy_push_first", seq_out, 32'h7);
    @(negedge HCLK); @(negedge HCLK);
    #1 check("busy_push_second", seq_out, 32'h8);
    wait_idle("busy_push_idle");

    // START and STOP together: STOP wins
    @(negedge HCLK);
    apb_wr(A_DATA, 32'h55);
    apb_wr(A_CTRL, 32'h3);
    #1 check("startstop_active", {31'b0, seq_active}, 32'd0);
    apb_rd(A_STAT, rdata); check("startstop_status", rdata, 32'h4);

    // Reset asserted mid-HOLD
    apb_wr(A_HOLD, 32'd5); apb_wr(A_DATA, 32'h3C);
    apb_wr(A_CTRL, 32'h1);
    @(negedge HCLK); @(negedge HCLK);
    #1 check("prerst_out", seq_out, 32'h3C);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_out", seq_out, 32'h0);
    check("midrst_active", {31'b0, seq_active}, 32'd0);
    check("midrst_done", {31'b0, seq_done}, 32'd0);
    PADDR = A_STAT;
    #1 check("midrst_status", PRDATA, 32'h4);
    @(negedge HCLK); HRESETn = 1'b1;
    apb_wr(A_HOLD, 32'h1234); apb_rd(A_HOLD, rdata); check("first_access", rdata, 32'h1234);
    apb_wr(A_CTRL, 32'h1); #1 check("postrst_start", {31'b0, seq_active}, 32'd0);
    @(negedge HCLK);

`ifdef GPIO_SEQ_LOOP_EN
    // LOOP mode: 1,1,2,2,... with the FIFO level held at 2
    apb_wr(A_HOLD, 32'd0); apb_wr(A_DATA, 32'h1); apb_wr(A_DATA, 32'h2);
    apb_wr(A_CTRL, 32'h5);
    run_trace();
    e_out  = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h1, 32'h1, 32'h2};
    e_done = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_busy = '{1, 1, 1, 1, 1, 1, 1, 1};
    e_lvl  = '{2, 2, 2, 2, 2, 2, 2, 2};
    cmp_trace("loop");
    apb_wr(A_CTRL, 32'h2);
    #1;
    check("loop_stop_active", {31'b0, seq_active}, 32'd0);
    check("loop_stop_done", {31'b0, seq_done}, 32'd0);
    apb_rd(A_STAT, rdata); check("loop_stop_status", rdata, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_gpio_seq.md
APB_GPIO_SEQ -- requirements
Module: apb_gpio_seq

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, APB address width; only PADDR[4:2] are decoded.
REQ-002 Parameter FIFO_DEPTH, default 4, number of command FIFO entries; power of two, 2..16.
REQ-003 HCLK  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 PADDR  input  APB_ADDR_WIDTH  APB address.
REQ-006 PWDATA  input  32  APB write data.
REQ-007 PWRITE, PSEL, PENABLE  input  1 each  APB control.
REQ-008 PRDATA  output  32  read data, combinational from PADDR[4:2].
REQ-009 PREADY  output  1  tied 1.
REQ-010 PSLVERR  output  1  tied 0.
REQ-011 seq_out  output  32  sequenced pattern, intended for the GPIO block's output path.
REQ-012 seq_active  output  1  high while the sequencer owns the pads (LOAD or HOLD).
REQ-013 seq_done  output  1  one-cycle pulse when a sequence ends naturally.

Function
REQ-014 An APB access SHALL take effect in the cycle where PSEL && PENABLE; there are no wait states.
REQ-015 Register map (PADDR[4:2]): 0 CTRL, 1 STATUS, 2 HOLD, 3 DATA, 4 OUT; other offsets read 0 and ignore writes.
REQ-016 CTRL writes: bit0 START (self-clearing); bit1 STOP (self-clearing); bit2 LOOP (stored). CTRL reads return {29'b0, LOOP, 2'b0}.
REQ-017 STATUS read SHALL return {16'b0, level[7:0], 4'b0, overflow, empty, full, busy}; level is the FIFO occupancy.
REQ-018 HOLD SHALL be a 16-bit read/write register (bits 15:0); the upper bits read 0.
REQ-019 A write to DATA SHALL push {PWDATA, HOLD} into the FIFO. DATA reads return 0.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-021 Otherwise the push SHALL be dropped and sticky overflow set.
REQ-022 A STATUS read SHALL clear overflow in the same access cycle; a simultaneous new overflow wins.
REQ-023 OUT SHALL read the current seq_out.
REQ-024 FSM states SHALL be IDLE, LOAD and HOLD.
REQ-025 IDLE -> LOAD on START when the FIFO is non-empty; START on an empty FIFO is ignored.
REQ-026 In LOAD, the head entry SHALL be popped; at the edge leaving LOAD, seq_out <= data and cnt <= hold; next state HOLD.
REQ-027 In HOLD, when cnt != 0 the FSM SHALL decrement cnt.
REQ-028 In HOLD, when cnt == 0: go to LOAD if the FIFO is non-empty, else go to IDLE and pulse seq_done in the first IDLE cycle.
REQ-029 Each entry value SHALL persist exactly hold+2 cycles, except the last, which persists until the next update.
REQ-030 STOP in LOAD or HOLD SHALL go to IDLE next cycle, flush the FIFO, leave seq_out unchanged and not pulse seq_done.
REQ-031 STOP in IDLE SHALL flush the FIFO only.
REQ-032 START while busy SHALL be ignored.
REQ-033 When START and STOP are written together, STOP SHALL win.
REQ-034 busy = seq_active = (state != IDLE).
REQ-035 Pushes SHALL be accepted while busy; entries pushed before the HOLD-exit decision are played.

Reset
REQ-036 On HRESETn low, asynchronously: state IDLE, FIFO empty, pointers 0, overflow 0, LOOP 0, HOLD 0, cnt 0, seq_out 0, seq_active 0, seq_done 0.
REQ-037 Reset asserted mid-sequence SHALL abort with no seq_done pulse.
REQ-038 After reset deassertion, the first APB access cycle SHALL be honored.

Configuration
REQ-039 With macro GPIO_SEQ_LOOP_EN defined, LOAD with LOOP=1 SHALL read the head entry without removing it.
REQ-040 With GPIO_SEQ_LOOP_EN defined, the read pointer SHALL wrap over the stored entries and the sequence SHALL repeat until STOP; seq_done never pulses.
REQ-041 Without GPIO_SEQ_LOOP_EN, the LOOP bit SHALL not be implemented (reads 0) and the FIFO SHALL always pop.

Verification
REQ-042 HOLD=3; push 0xA5; START -> seq_out=0xA5 for 5 cycles; seq_done pulses once; busy 0 afterwards.
REQ-043 Push 0x1 (HOLD=0) then 0x2 (HOLD=1); START -> seq_out 0x1 for 2 cycles, then 0x2; STATUS level goes 2, 1, 0.
REQ-044 FIFO_DEPTH=4; 5 pushes while IDLE -> full=1, overflow=1; STATUS read returns overflow 1; next STATUS read returns overflow 0.
REQ-045 STOP during the HOLD of entry 1 of 3 -> IDLE next cycle; seq_out holds entry 1; empty=1; no seq_done.
REQ-046 GPIO_SEQ_LOOP_EN, LOOP=1, entries 0x1/0x2 with HOLD=0 -> pattern 1,1,2,2,1,1,... until STOP; level stays 2.
REQ-047 Assert HRESETn mid-HOLD -> all outputs 0 immediately; a subsequent START with an empty FIFO stays IDLE.
